// File: rtl/moving_average_ring_if.sv
// Sample/average bus of the sliding-window averager: enable/data_refresh strobe in,
// registered average with output_pulse strobe out.
interface moving_average_ring_if #(
  parameter int DW = 16
);
  logic                 enable;
  logic                 data_refresh;
  logic                 clear;
  logic                 output_refresh_mode;
  logic [2:0]           win_sel;
  logic signed [DW-1:0] din;
  logic signed [DW-1:0] dout;
  logic                 output_pulse;
  logic                 window_full;

  modport master (
    output enable, data_refresh, clear, output_refresh_mode, win_sel, din,
    input  dout, output_pulse, window_full
  );

  modport slave (
    input  enable, data_refresh, clear, output_refresh_mode, win_sel, din,
    output dout, output_pulse, window_full
  );
endinterface

// File: rtl/moving_average_ring.sv
// True sliding-window average over 2^k samples (ring buffer + running sum).
// Latency 1: dout/output_pulse register on the edge that accepts the sample; no backpressure.
module moving_average_ring #(
  parameter int DW         = 16,
  parameter int LOG2_MAX_N = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  moving_average_ring_if.slave bus
);
  localparam int SW    = DW + LOG2_MAX_N;
  localparam int DEPTH = 1 << LOG2_MAX_N;

  logic signed [DW-1:0]   mem [DEPTH];

  logic signed [SW-1:0]   sum_q, sum_d;
  logic [LOG2_MAX_N:0]    fill_q, fill_d;
  logic [LOG2_MAX_N-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG2_MAX_N-1:0]  phase_q, phase_d;
  logic [2:0]             k_q, k_d;
  logic signed [DW-1:0]   dout_q, dout_d;
  logic                   pulse_q, pulse_d;
  logic                   full_q, full_d;

  logic [2:0]             k_eff;
  logic [LOG2_MAX_N:0]    n_val;
  logic [LOG2_MAX_N-1:0]  last_phase;
  logic [LOG2_MAX_N-1:0]  rd_idx;
  logic                   win_chg;
  logic                   accept;
  logic signed [SW-1:0]   sum_base, din_ext, oldest_ext, sum_next;
  logic [LOG2_MAX_N:0]    fill_base, fill_next;
  logic [LOG2_MAX_N-1:0]  phase_base;

  assign k_eff      = ({29'd0, bus.win_sel} > LOG2_MAX_N) ? 3'(LOG2_MAX_N) : bus.win_sel;
  assign n_val      = (LOG2_MAX_N+1)'(1) << k_eff;
  assign last_phase = LOG2_MAX_N'(n_val - 1'b1);
  assign win_chg    = bus.enable && (k_eff != k_q);
  assign accept     = bus.enable && bus.data_refresh && !bus.clear;

  // A window change restarts history, and a same-cycle sample opens the new window.
  assign sum_base   = win_chg ? '0 : sum_q;
  assign fill_base  = win_chg ? '0 : fill_q;
  assign phase_base = win_chg ? '0 : phase_q;

  // At N = DEPTH the index wraps onto wr_ptr itself: the slot about to be overwritten.
  assign rd_idx     = wr_ptr_q - n_val[LOG2_MAX_N-1:0];
  assign din_ext    = {{LOG2_MAX_N{bus.din[DW-1]}}, bus.din};
  assign oldest_ext = (fill_base >= n_val) ? {{LOG2_MAX_N{mem[rd_idx][DW-1]}}, mem[rd_idx]} : '0;
  assign sum_next   = sum_base + din_ext - oldest_ext;
  assign fill_next  = (fill_base < n_val) ? fill_base + 1'b1 : fill_base;

  always_comb begin
    sum_d    = sum_q;
    fill_d   = fill_q;
    wr_ptr_d = wr_ptr_q;
    phase_d  = phase_q;
    k_d      = k_q;
    dout_d   = dout_q;
    full_d   = full_q;
    pulse_d  = 1'b0;
    if (bus.enable) begin
      k_d = k_eff;
      if (bus.clear || win_chg) begin
        sum_d   = '0;
        fill_d  = '0;
        phase_d = '0;
        full_d  = 1'b0;
      end
      if (accept) begin
        sum_d    = sum_next;
        fill_d   = fill_next;
        wr_ptr_d = wr_ptr_q + 1'b1;
        phase_d  = (phase_base == last_phase) ? '0 : phase_base + 1'b1;
        dout_d   = DW'(sum_next >>> k_eff);
        full_d   = (fill_next >= n_val);
        pulse_d  = bus.output_refresh_mode || (phase_base == last_phase);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q    <= '0;
      fill_q   <= '0;
      wr_ptr_q <= '0;
      phase_q  <= '0;
      k_q      <= '0;
      dout_q   <= '0;
      pulse_q  <= 1'b0;
      full_q   <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      fill_q   <= fill_d;
      wr_ptr_q <= wr_ptr_d;
      phase_q  <= phase_d;
      k_q      <= k_d;
      dout_q   <= dout_d;
      pulse_q  <= pulse_d;
      full_q   <= full_d;
    end
  end

  // Sample storage is deliberately unreset; fill decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= bus.din;
  end

  assign bus.dout         = dout_q;
  assign bus.output_pulse = pulse_q;
  assign bus.window_full  = full_q;
endmodule

// File: tb/tb_moving_average_ring.sv
// Bench for moving_average_ring: a history-based reference model predicts every cycle,
// expectations go through a scoreboard queue and are checked one cycle later.
module tb_moving_average_ring;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  moving_average_ring_if #(.DW(16)) bus ();

  moving_average_ring #(.DW(16), .LOG2_MAX_N(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               p;
    logic               wf;
    logic signed [15:0] d;
  } exp_t;

  exp_t               sb[$];
  int                 hist[$];
  int                 m_phase;
  int                 m_k;
  logic signed [15:0] m_dout;
  logic               m_wf;

  task automatic model_reset();
    hist.delete();
    m_phase = 0;
    m_k     = 0;
    m_dout  = '0;
    m_wf    = 1'b0;
  endtask

  // Drive one cycle, predict from the explicit sample history, compare after the edge.
  task automatic cycle(input string name, input logic en, input logic dr, input logic clr,
                       input logic [2:0] ws, input logic mode, input int d);
    exp_t   e;
    int     ke, n, m;
    longint s;
    bus.enable              = en;
    bus.data_refresh        = dr;
    bus.clear               = clr;
    bus.win_sel             = ws;
    bus.output_refresh_mode = mode;
    bus.din                 = 16'(d);
    e.p = 1'b0;
    ke  = (ws > 3'd4) ? 4 : int'(ws);
    n   = 1 << ke;
    if (en) begin
      if (ke != m_k || clr) begin
        hist.delete();
        m_phase = 0;
        m_wf    = 1'b0;
        m_k     = ke;
      end
      if (!clr && dr) begin
        hist.push_back(d);
        if (hist.size() > 16) void'(hist.pop_front());
        m = (hist.size() < n) ? hist.size() : n;
        s = 0;
        for (int i = 0; i < m; i++) s += hist[hist.size() - 1 - i];
        m_dout  = 16'(s >>> ke);
        m_wf    = (hist.size() >= n);
        e.p     = mode || (m_phase == n - 1);
        m_phase = (m_phase + 1) % n;
      end
    end
    e.wf = m_wf;
    e.d  = m_dout;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (bus.output_pulse !== e.p) begin
      errors++;
      $display("FAIL %s pulse: got %b expected %b", name, bus.output_pulse, e.p);
    end
    checks++;
    if (bus.window_full !== e.wf) begin
      errors++;
      $display("FAIL %s window_full: got %b expected %b", name, bus.window_full, e.wf);
    end
    checks++;
    if (bus.dout !== e.d) begin
      errors++;
      $display("FAIL %s dout: got %0d expected %0d", name, bus.dout, e.d);
    end
  endtask

  task automatic check_dout(input string name, input int exp_d);
    checks++;
    if (bus.dout !== 16'(exp_d)) begin
      errors++;
      $display("FAIL %s: dout got %0d expected %0d", name, bus.dout, exp_d);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0; bus.data_refresh = 1'b0; bus.clear = 1'b0;
    bus.win_sel = '0; bus.output_refresh_mode = 1'b0; bus.din = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.dout, bus.output_pulse, bus.window_full} !== 18'd0) begin
      errors++;
      $display("FAIL reset: outputs got %h expected 0", {bus.dout, bus.output_pulse, bus.window_full});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_ramp_every_sample();
    int samples[5] = '{4, 8, 12, 16, 20};
    int expd[5]    = '{1, 3, 6, 10, 14};
    foreach (samples[i]) begin
      cycle("ramp", 1, 1, 0, 3'd2, 1, samples[i]);
      check_dout("ramp_const", expd[i]);
    end
    cycle("ramp_idle", 1, 0, 0, 3'd2, 1, 0);
  endtask

  task automatic test_negative_floor();
    cycle("neg", 1, 1, 0, 3'd1, 1, -3);
    check_dout("neg_first", -2);
    cycle("neg", 1, 1, 0, 3'd1, 1, -4);
    check_dout("neg_second", -4);
  endtask

  task automatic test_decimated();
    cycle("dec_clr", 1, 0, 1, 3'd2, 0, 0);
    for (int i = 0; i < 8; i++) cycle("dec", 1, 1, 0, 3'd2, 0, 100);
    check_dout("dec_const", 100);
  endtask

  task automatic test_wrap();
    cycle("wrap_clr", 1, 0, 1, 3'd4, 1, 0);
    for (int i = 0; i < 32; i++) cycle("wrap", 1, 1, 0, 3'd4, 1, i);
    check_dout("wrap_const", 23);
    cycle("clamp", 1, 1, 0, 3'd7, 1, -500);
  endtask

  task automatic test_winsel_and_clear();
    for (int i = 0; i < 3; i++) cycle("pre", 1, 1, 0, 3'd2, 0, 11 * i);
    cycle("k_to_0", 1, 1, 0, 3'd0, 0, 7);
    check_dout("k0_dout", 7);
    checks++;
    if (bus.window_full !== 1'b1) begin
      errors++;
      $display("FAIL k0_full: got %b expected 1", bus.window_full);
    end
    cycle("k0_next", 1, 1, 0, 3'd0, 0, -9);
    cycle("clr_drop", 1, 1, 1, 3'd2, 1, 99);
    cycle("after_clr", 1, 1, 0, 3'd2, 1, 40);
    check_dout("after_clr_const", 10);
  endtask

  task automatic test_enable_and_async_reset();
    for (int i = 0; i < 3; i++) cycle("en_off", 0, 1, i == 1, 3'd3, 1, 1000);
    cycle("en_on", 1, 1, 0, 3'd2, 1, 60);
    cycle("en_on", 1, 1, 0, 3'd2, 1, 20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({bus.dout, bus.output_pulse, bus.window_full} !== 18'd0) begin
      errors++;
      $display("FAIL async_reset: outputs got %h expected 0", {bus.dout, bus.output_pulse, bus.window_full});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle("post_rst", 1, 1, 0, 3'd2, 1, 8);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      cycle("rand", 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 19) == 0), 3'($urandom_range(0, 5)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 65535)) - 32768);
  endtask

  initial begin
    test_reset();
    test_ramp_every_sample();
    test_negative_floor();
    test_decimated();
    test_wrap();
    test_winsel_and_clear();
    test_enable_and_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/moving_average_ring.md
Name: moving_average_ring

Overview:
- Parametrised true sliding-window moving-average filter.
- Stores the last 2^LOG2_MAX_N samples in a ring buffer and keeps a running sum: each accepted sample adds the newest value and subtracts the exact sample leaving the window.
- Window length is selectable at runtime as 2^win_sel. Output is either every sample or decimated once per window.
- Sits between the ADC sample front-end and downstream control logic. Uses the same enable / data_refresh / output_pulse protocol as the existing averagers.

Parameters:
- DW, 16, input/output sample width (signed two's complement)
- LOG2_MAX_N, 4, log2 of maximum window depth; ring buffer holds 2^LOG2_MAX_N samples

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  block enable; low = hold all state
- data_refresh  in  1  single-cycle sample strobe; sample accepted when enable & data_refresh
- clear  in  1  synchronous flush of window history
- output_refresh_mode  in  1  1 = pulse every sample, 0 = pulse once per N samples
- win_sel  in  3  log2 window length k; N = 2^k; values > LOG2_MAX_N clamp to LOG2_MAX_N
- din  in  DW  signed input sample
- dout  out  DW  signed average, registered
- output_pulse  out  1  single-cycle valid strobe for dout
- window_full  out  1  high once N samples have been accepted since the last flush

Behaviour:
- Reset (async): dout=0, output_pulse=0, window_full=0, sum=0, fill=0, wr_ptr=0, phase=0, latched k=0. Buffer RAM is not reset; contents are gated by fill.
- Accumulator: signed, width DW+LOG2_MAX_N, cannot overflow. Buffer pointer arithmetic is modulo 2^LOG2_MAX_N.
- Accepted sample:
  - oldest = (fill >= N) ? buf[wr_ptr - N] : 0, read before write. At N = max this is the slot being overwritten.
  - sum <= sum + din - oldest
  - buf[wr_ptr] <= din; wr_ptr++
  - fill saturates at N
- Output:
  - dout <= (sum_next >>> k), arithmetic shift, truncation toward -inf. Registered on the same edge the sample is accepted, so it is visible the next cycle (latency 1).
  - Before the window fills, missing history counts as zero, so dout ramps up.
  - N=1 (k=0): dout = din.
- window_full <= (fill_next >= N).
- output_pulse:
  - Default 0 every cycle.
  - On an accepted sample: 1 if output_refresh_mode=1. Otherwise 1 only when phase == N-1.
  - phase increments per accepted sample modulo N and resets with any flush.
- win_sel change: compared against latched k each cycle. On a difference:
  - Flush: sum=0, fill=0, phase=0, window_full=0; latch new k.
  - A sample accepted in the same cycle becomes the first sample of the new window.
  - dout is not cleared.
- clear=1: flush as above. A concurrent sample is dropped (no write, no pulse). clear takes priority over a win_sel change, but k is still latched.
- enable=0: no state change, output_pulse=0, dout held. data_refresh and clear are ignored.
- data_refresh held high for several cycles: one sample is accepted per cycle.
- Reset mid-stream: immediate return to reset values. The first post-reset sample is treated as fill=0.

Test Plan:
1. win_sel=2, mode=1, samples 4,8,12,16,20 -> dout 1,3,6,10,14; output_pulse on each sample; window_full rises with the 4th sample.
2. win_sel=1, mode=1, samples -3,-4 -> dout -2, -4 (arithmetic floor).
3. win_sel=2, mode=0, eight samples of 100 -> output_pulse only on the 4th and 8th; dout=100 at both.
4. win_sel=4, ramp 0..31 -> after the 32nd sample dout=23 (sum 376), confirming ring wrap-around with exact oldest-sample removal.
5. win_sel 2->0 with concurrent din=7 -> dout=7, window_full=1, phase restarts. clear with concurrent sample -> no pulse, next sample 40 at k=2 gives dout=10.
6. enable=0 with data_refresh pulses -> dout/sum unchanged, no pulse. rst_n low mid-window -> all outputs 0 asynchronously, then ramp restarts from zero history.
